// File: rtl/uart_loader_pkg.sv
// Shared definitions for the serial program loader: start byte, FSM state
// encodings and the baud divider helper.
package uart_loader_pkg;

  localparam logic [7:0] START_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } ld_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// ROM write port and loader status, driven by the loader (master) and
// observed by the ROM/CPU side (slave).
interface uart_loader_if;

  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o
  );

  modport slave (
    input wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o
  );

endinterface

// File: rtl/uart_loader_uart_rx.sv
// 8N1 UART receiver on an already synchronized line; emits one rx_valid
// pulse per byte at the stop-bit centre and drops framing-error bytes.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sync,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(DIV - 1);

  rx_state_t   state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  // After a low stop bit, wait for the line to go high so the tail of the
  // bad frame is not mistaken for a new start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= RX_IDLE;
            end else begin
              state <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Serial program loader: receives A5/LEN/data frames over UART and writes
// 32-bit words to the ROM. Define UART_LOADER_CHECKSUM_EN for a trailing XOR byte.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int MAX_WORDS   = 32,
  parameter int TIMEOUT_CYC = 16 * calc_div(CLK_FREQ, BAUD) * 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx_i,
  uart_loader_if.master bus
);

  localparam int          DIV      = calc_div(CLK_FREQ, BAUD);
  localparam logic [31:0] GAP_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_WORDS);

  logic        sync_1;
  logic        sync_2;
  logic [7:0]  rx_data;
  logic        rx_valid;
  ld_state_t   state;
  logic [15:0] len;
  logic [15:0] widx;
  logic [1:0]  bcnt;
  logic [23:0] word;
  logic [31:0] gap_cnt;
  logic [15:0] new_len;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= uart_rx_i;
      sync_2 <= sync_1;
    end
  end

  uart_rx #(.DIV(DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_sync  (sync_2),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  assign new_len = {rx_data, len[7:0]};

  // Status outputs change on the same edge that consumes the final byte, so
  // done/err rise one cycle after its valid pulse; DONE/ERR just return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      len            <= '0;
      widx           <= '0;
      bcnt           <= '0;
      word           <= '0;
      gap_cnt        <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
      bus.wr_en_o    <= 1'b0;
      bus.wr_addr_o  <= '0;
      bus.wr_data_o  <= '0;
      bus.cpu_hold_o <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.err_o      <= 1'b0;
    end else begin
      bus.wr_en_o <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (rx_valid && rx_data == START_BYTE) begin
            state          <= LEN_LO;
            widx           <= '0;
            bcnt           <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
            bus.cpu_hold_o <= 1'b1;
            bus.done_o     <= 1'b0;
            bus.err_o      <= 1'b0;
          end
        end
        DONE, ERR: state <= IDLE;
        default: begin
          if (rx_valid) begin
            gap_cnt <= '0;
            case (state)
              LEN_LO: begin
                len[7:0] <= rx_data;
                state    <= LEN_HI;
              end
              LEN_HI: begin
                len[15:8] <= rx_data;
                if (new_len > MAX_LEN) begin
                  state          <= ERR;
                  bus.err_o      <= 1'b1;
                  bus.cpu_hold_o <= 1'b0;
                end else if (new_len == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                  state          <= CSUM;
`else
                  state          <= DONE;
                  bus.done_o     <= 1'b1;
                  bus.cpu_hold_o <= 1'b0;
`endif
                end else begin
                  state <= DATA;
                end
              end
              DATA: begin
`ifdef UART_LOADER_CHECKSUM_EN
                csum <= csum ^ rx_data;
`endif
                bcnt <= bcnt + 2'd1;
                case (bcnt)
                  2'd0: word[7:0]   <= rx_data;
                  2'd1: word[15:8]  <= rx_data;
                  2'd2: word[23:16] <= rx_data;
                  default: begin
                    bus.wr_en_o   <= 1'b1;
                    bus.wr_addr_o <= {14'd0, widx, 2'b00};
                    bus.wr_data_o <= {rx_data, word};
                    widx          <= widx + 16'd1;
                    if (widx + 16'd1 == len) begin
`ifdef UART_LOADER_CHECKSUM_EN
                      state          <= CSUM;
`else
                      state          <= DONE;
                      bus.done_o     <= 1'b1;
                      bus.cpu_hold_o <= 1'b0;
`endif
                    end
                  end
                endcase
              end
`ifdef UART_LOADER_CHECKSUM_EN
              CSUM: begin
                bus.cpu_hold_o <= 1'b0;
                if (rx_data == csum) begin
                  state      <= DONE;
                  bus.done_o <= 1'b1;
                end else begin
                  state     <= ERR;
                  bus.err_o <= 1'b1;
                end
              end
`endif
              default: begin
                state          <= ERR;
                bus.err_o      <= 1'b1;
                bus.cpu_hold_o <= 1'b0;
              end
            endcase
          end else if (gap_cnt == GAP_LAST) begin
            state          <= ERR;
            bus.err_o      <= 1'b1;
            bus.cpu_hold_o <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader at DIV=10; adapts to UART_LOADER_CHECKSUM_EN.
module tb_uart_loader;

  localparam int DIV     = 10;
  localparam int TIMEOUT = 16 * DIV * 10;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx_i;

  uart_loader_if bus ();

  uart_loader #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .MAX_WORDS (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx_i (uart_rx_i),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int last_stop_cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int done_rise = -1;
  int err_rise = -1;
  logic done_prev = 1'b0;
  logic err_prev = 1'b0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write-strobe cycle and the cycle on which done/err rise.
  always @(posedge clk) begin
    #1;
    if (bus.wr_en_o === 1'b1) begin
      wr_addr_q.push_back(bus.wr_addr_o);
      wr_data_q.push_back(bus.wr_data_o);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.done_o === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
    if (bus.err_o === 1'b1 && err_prev !== 1'b1) err_rise = cyc;
    done_prev = bus.done_o;
    err_prev  = bus.err_o;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx_i = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (DIV) @(negedge clk);
    end
    last_stop_cyc = cyc;
    uart_rx_i = stop_bit;
    repeat (DIV) @(negedge clk);
    uart_rx_i = 1'b1;
  endtask

  task automatic send_csum(input logic [7:0] b);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(b, 1'b1);
`else
    b = b;
`endif
  endtask

  task automatic clear_log();
    repeat (3 * DIV) @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_rise = -1;
    err_rise  = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rx_i = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.wr_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_en: got %b expected 0", bus.wr_en_o); end
    n_checks++; if (bus.wr_addr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %h expected 0", bus.wr_addr_o); end
    n_checks++; if (bus.wr_data_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wr_data: got %h expected 0", bus.wr_data_o); end
    n_checks++; if (bus.cpu_hold_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hold: got %b expected 0", bus.cpu_hold_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done_o); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err_o); end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    int exp_wr0;
    int exp_wr1;
    int exp_done;
    clear_log();
    send_byte(8'hA5, 1'b1);
    n_checks++; if (bus.cpu_hold_o !== 1'b1) begin n_fail++; $display("[TB] FAIL good_hold_set: got %b expected 1", bus.cpu_hold_o); end
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    exp_wr0 = last_stop_cyc + 9;
    send_byte(8'h6F, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    exp_wr1 = last_stop_cyc + 9;
    send_csum(8'h7C);
    exp_done = last_stop_cyc + 9;
    repeat (2 * DIV) @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== 2) begin n_fail++; $display("[TB] FAIL good_wr_count: got %0d expected 2", wr_addr_q.size()); end
    if (wr_addr_q.size() > 1) begin
      n_checks++; if (wr_addr_q[0] !== 32'h0) begin n_fail++; $display("[TB] FAIL good_addr0: got %h expected 0", wr_addr_q[0]); end
      n_checks++; if (wr_data_q[0] !== 32'h13) begin n_fail++; $display("[TB] FAIL good_data0: got %h expected 13", wr_data_q[0]); end
      n_checks++; if (wr_cyc_q[0] !== exp_wr0) begin n_fail++; $display("[TB] FAIL good_wr0_cycle: got %0d expected %0d", wr_cyc_q[0], exp_wr0); end
      n_checks++; if (wr_addr_q[1] !== 32'h4) begin n_fail++; $display("[TB] FAIL good_addr1: got %h expected 4", wr_addr_q[1]); end
      n_checks++; if (wr_data_q[1] !== 32'h6F) begin n_fail++; $display("[TB] FAIL good_data1: got %h expected 6f", wr_data_q[1]); end
      n_checks++; if (wr_cyc_q[1] !== exp_wr1) begin n_fail++; $display("[TB] FAIL good_wr1_cycle: got %0d expected %0d", wr_cyc_q[1], exp_wr1); end
    end
    n_checks++; if (bus.wr_data_o !== 32'h6F) begin n_fail++; $display("[TB] FAIL good_data_hold: got %h expected 6f", bus.wr_data_o); end
    n_checks++; if (done_rise !== exp_done) begin n_fail++; $display("[TB] FAIL good_done_cycle: got %0d expected %0d", done_rise, exp_done); end
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("[TB] FAIL good_done: got %b expected 1", bus.done_o); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL good_err: got %b expected 0", bus.err_o); end
    n_checks++; if (bus.cpu_hold_o !== 1'b0) begin n_fail++; $display("[TB] FAIL good_hold_clr: got %b expected 0", bus.cpu_hold_o); end
  endtask

  task automatic test_bad_checksum();
`ifdef UART_LOADER_CHECKSUM_EN
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h6F, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== 2) begin n_fail++; $display("[TB] FAIL csum_wr_count: got %0d expected 2", wr_addr_q.size()); end
    n_checks++; if (bus.err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL csum_err: got %b expected 1", bus.err_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL csum_done: got %b expected 0", bus.done_o); end
    n_checks++; if (bus.cpu_hold_o !== 1'b0) begin n_fail++; $display("[TB] FAIL csum_hold: got %b expected 0", bus.cpu_hold_o); end
`endif
  endtask

  task automatic test_len_too_big();
    int exp_err;
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h21, 1'b1); send_byte(8'h00, 1'b1);
    exp_err = last_stop_cyc + 9;
    repeat (2 * DIV) @(negedge clk);
    n_checks++; if (err_rise !== exp_err) begin n_fail++; $display("[TB] FAIL len_err_cycle: got %0d expected %0d", err_rise, exp_err); end
    n_checks++; if (wr_addr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL len_wr_count: got %0d expected 0", wr_addr_q.size()); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL len_done: got %b expected 0", bus.done_o); end
  endtask

  task automatic test_zero_len();
    int exp_done;
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_csum(8'h00);
    exp_done = last_stop_cyc + 9;
    repeat (2 * DIV) @(negedge clk);
    n_checks++; if (done_rise !== exp_done) begin n_fail++; $display("[TB] FAIL zero_done_cycle: got %0d expected %0d", done_rise, exp_done); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_err: got %b expected 0", bus.err_o); end
    n_checks++; if (wr_addr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL zero_wr_count: got %0d expected 0", wr_addr_q.size()); end
  endtask

  task automatic test_timeout();
    int exp_err;
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hAA, 1'b1);
    exp_err = last_stop_cyc + 9 + TIMEOUT;
    repeat (TIMEOUT + 4 * DIV) @(negedge clk);
    n_checks++; if (err_rise !== exp_err) begin n_fail++; $display("[TB] FAIL timeout_cycle: got %0d expected %0d", err_rise, exp_err); end
    n_checks++; if (bus.err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err: got %b expected 1", bus.err_o); end
    n_checks++; if (bus.cpu_hold_o !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_hold: got %b expected 0", bus.cpu_hold_o); end
    n_checks++; if (wr_addr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL timeout_wr_count: got %0d expected 0", wr_addr_q.size()); end
  endtask

  task automatic test_start_in_data();
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'hA5, 1'b1); send_byte(8'hA5, 1'b1); send_byte(8'hA5, 1'b1);
    send_csum(8'h00);
    repeat (2 * DIV) @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("[TB] FAIL a5_wr_count: got %0d expected 1", wr_addr_q.size()); end
    if (wr_addr_q.size() > 0) begin
      n_checks++; if (wr_data_q[0] !== 32'hA5A5A5A5) begin n_fail++; $display("[TB] FAIL a5_data: got %h expected a5a5a5a5", wr_data_q[0]); end
    end
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("[TB] FAIL a5_done: got %b expected 1", bus.done_o); end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    uart_rx_i = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.cpu_hold_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_hold: got %b expected 0", bus.cpu_hold_o); end
    n_checks++; if (bus.wr_addr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_addr: got %h expected 0", bus.wr_addr_o); end
    n_checks++; if (bus.wr_data_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_data: got %h expected 0", bus.wr_data_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_done: got %b expected 0", bus.done_o); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_err: got %b expected 0", bus.err_o); end
    uart_rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    send_csum(8'h08);
    repeat (2 * DIV) @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("[TB] FAIL rstmid_wr_count: got %0d expected 1", wr_addr_q.size()); end
    if (wr_addr_q.size() > 0) begin
      n_checks++; if (wr_addr_q[0] !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_new_addr: got %h expected 0", wr_addr_q[0]); end
      n_checks++; if (wr_data_q[0] !== 32'h12345678) begin n_fail++; $display("[TB] FAIL rstmid_new_data: got %h expected 12345678", wr_data_q[0]); end
    end
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_new_done: got %b expected 1", bus.done_o); end
  endtask

  task automatic test_framing_error();
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'hFF, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_csum(8'h04);
    repeat (2 * DIV) @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("[TB] FAIL frame_wr_count: got %0d expected 1", wr_addr_q.size()); end
    if (wr_addr_q.size() > 0) begin
      n_checks++; if (wr_data_q[0] !== 32'h04030201) begin n_fail++; $display("[TB] FAIL frame_data: got %h expected 04030201", wr_data_q[0]); end
    end
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("[TB] FAIL frame_done: got %b expected 1", bus.done_o); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL frame_err: got %b expected 0", bus.err_o); end
  endtask

  initial begin
    rst = 1'b1;
    uart_rx_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_too_big();
    test_zero_len();
    test_timeout();
    test_start_in_data();
    test_reset_mid_frame();
    test_framing_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Serial program loader sitting directly upstream of the instruction/data ROM. It receives a framed image over a UART line and assembles little-endian 32-bit words. It drives the ROM write port (`wr_en`/`wr_addr`/`wr_data`) one word at a time and holds the CPU core while an image is in flight. After the last word it reports success or failure.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, UART bit rate; bit period `DIV = CLK_FREQ / BAUD` (integer, truncated).
- `MAX_WORDS`, 32, ROM depth in words; larger images are rejected.
- `TIMEOUT_CYC`, 16*DIV*10, maximum idle cycles between bytes inside a frame.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `uart_rx_i`  in  1  serial line, idle high, 8N1, asynchronous to `clk`.
- `wr_en_o`  out  1  ROM write strobe, one-cycle pulse per word.
- `wr_addr_o`  out  32  ROM byte address, word-aligned.
- `wr_data_o`  out  32  ROM write word.
- `cpu_hold_o`  out  1  high while a frame is being loaded; the CPU stays stalled/reset.
- `done_o`  out  1  sticky: last frame loaded successfully.
- `err_o`  out  1  sticky: last frame aborted or failed.

## Operation
- Frame, byte order on the line: `0xA5` start; `LEN_LO`; `LEN_HI` (word count N, 16 bit); N×4 data bytes, each word LSB first; optionally one checksum byte (see Configuration).
- FSM states and transitions:
  - IDLE: a byte equal to `0xA5` moves to LEN_LO, sets `cpu_hold_o`, and clears `done_o`/`err_o`. Any other byte is ignored.
  - LEN_LO: the next byte is latched into `len[7:0]`; go to LEN_HI.
  - LEN_HI: the next byte is latched into `len[15:8]`.
    - If `len > MAX_WORDS`, go to ERR.
    - If `len == 0`, go to CSUM, or to DONE when checksum is compiled out.
    - Otherwise go to DATA.
  - DATA: 2-bit byte counter `bcnt` shifts each byte into `word[8*bcnt +: 8]`.
    - When `bcnt == 3`, issue a write with `wr_addr_o = widx << 2` and `wr_data_o` = the assembled word.
    - Then increment `widx`.
    - When `widx` reaches `len`, go to CSUM or DONE.
  - CSUM: compare the received byte with the running checksum. Equal goes to DONE; otherwise go to ERR.
  - DONE: set `done_o`, drop `cpu_hold_o`, return to IDLE.
  - ERR: set `err_o`, drop `cpu_hold_o`, return to IDLE.
- Timeout: in any state other than IDLE, a gap of more than `TIMEOUT_CYC` cycles with no received byte goes to ERR. The gap counter clears on every received byte.
- Words already written before an ERR are not undone. `err_o` is the only indication.
- A `0xA5` byte arriving mid-frame is treated as data; it does not restart the frame.
- The receiver discards bytes with a framing error (stop bit low). Such bytes do not advance the FSM and do not reset the gap counter.

## Timing
- Reset values: `wr_en_o=0`, `wr_addr_o=0`, `wr_data_o=0`, `cpu_hold_o=0`, `done_o=0`, `err_o=0`. FSM resets to IDLE; the synchronizer resets to 1 (line idle).
- `uart_rx_i` passes through a 2-flop synchronizer before any logic.
- Start-bit falling edge is re-checked at `DIV/2`. Data bits are sampled at bit centres, LSB first. The byte-valid pulse occurs at the stop-bit centre.
- `wr_en_o` asserts exactly one cycle, in the cycle after the valid pulse of the 4th byte of a word. `wr_addr_o`/`wr_data_o` are stable in that cycle and hold afterwards.
- `done_o`/`err_o` rise and `cpu_hold_o` falls in the same cycle, one cycle after the final byte (or the timeout) is recognised.
- Back-to-back bytes with zero idle time between stop and start bits are accepted.
- `rst` mid-frame aborts immediately: all outputs return to reset values and any partial word is dropped.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - A trailing checksum byte is expected, equal to the XOR of all N×4 data bytes (`0x00` for N=0).
  - A mismatch sets `err_o`.
- Not defined:
  - No checksum byte is expected.
  - DONE follows directly after the last data word, or after LEN_HI when N=0.

## Structure
- Shared package holds:
  - `START_BYTE = 8'hA5`;
  - the FSM state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR);
  - the `DIV` computation helper.
- Sub-module `uart_rx`:
  - inputs: clock, reset, synchronized line;
  - outputs: `rx_data[7:0]` and `rx_valid` (one-cycle pulse);
  - parameterised by `DIV`.
- The framing FSM, word assembly, checksum and timeout counter live in `uart_loader`.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD=100_000` (DIV=10), checksum enabled.
- Frame `A5 02 00 13 00 00 00 6F 00 00 00` plus checksum `7C` → two `wr_en_o` pulses:
  - addr 0x0 with data 0x00000013;
  - addr 0x4 with data 0x0000006F;
  - then `done_o=1`, `cpu_hold_o=0`.
- Same frame with checksum `00` → both words written, `err_o=1`, `done_o=0`.
- Length `21 00` (33 > MAX_WORDS) → no writes; `err_o=1` one cycle after `LEN_HI`.
- Send `A5 01 00 AA` then silence → `err_o=1` exactly `TIMEOUT_CYC+1` cycles after the `AA` valid pulse; no write.
- Assert `rst` during the 3rd data byte → all outputs 0 immediately. A following valid 1-word frame loads to addr 0x0.
- Byte with a low stop bit inside the data phase → byte ignored. The frame completes correctly once a valid byte is resent.
